// File: rtl/frequency_meter.sv
// Gated edge counter: counts rising edges of an asynchronous sig_in over GATE_CYCLES clk cycles.
// Optional macro FREQ_METER_PERIOD_EN adds period/period_ok outputs (cycles between the last two rises).
module frequency_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 28,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic             continuous,
    output logic             busy,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             overflow,
    output logic             valid
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [CNT_W-1:0] period,
    output logic             period_ok
`endif
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GATE  = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;

    logic [1:0]             state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic [GATE_W-1:0]      gate_cnt;
    logic [CNT_W-1:0]       edge_cnt;
    logic                   ovf_flag;
    logic                   win_clear;
    logic                   latch;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign busy = (state != IDLE);

    // A new window begins either from an idle start or back-to-back after LATCH.
    assign win_clear = ((state == IDLE) && start) || ((state == LATCH) && continuous);
    assign latch     = (state == LATCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
            freq_cnt <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (win_clear) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                ovf_flag <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) state <= GATE;
                end
                GATE: begin
                    gate_cnt <= gate_cnt + GATE_W'(1);
                    if (rise) begin
                        if (edge_cnt == CNT_MAX) ovf_flag <= 1'b1;
                        else                     edge_cnt <= edge_cnt + CNT_W'(1);
                    end
                    if (gate_cnt == GATE_LAST) state <= LATCH;
                end
                LATCH: begin
                    // Rises during this cycle are deliberately not counted.
                    freq_cnt <= edge_cnt;
                    overflow <= ovf_flag;
                    valid    <= 1'b1;
                    state    <= continuous ? GATE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_W-1:0] since_cnt;
    logic [CNT_W-1:0] period_last;
    logic             seen_one;
    logic             seen_two;

    // since_cnt is the number of cycles elapsed since the most recent counted rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            since_cnt   <= '0;
            period_last <= '0;
            seen_one    <= 1'b0;
            seen_two    <= 1'b0;
            period      <= '0;
            period_ok   <= 1'b0;
        end else begin
            if (latch) begin
                period    <= period_last;
                period_ok <= seen_two;
            end
            if (win_clear) begin
                since_cnt   <= '0;
                period_last <= '0;
                seen_one    <= 1'b0;
                seen_two    <= 1'b0;
            end else if (state == GATE) begin
                if (rise) begin
                    if (seen_one) begin
                        period_last <= since_cnt;
                        seen_two    <= 1'b1;
                    end
                    seen_one  <= 1'b1;
                    since_cnt <= CNT_W'(1);
                end else if (since_cnt != CNT_MAX) begin
                    since_cnt <= since_cnt + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule
